kr_pll_rst_seq: RTL and testbench
=================================

KR_PLL_RST_SEQ -- requirements
Module: kr_pll_rst_seq

Interface
REQ-001 Parameter PWRDN_CYC, default 200: cycles pll_powerdown is held high per attempt.
REQ-002 Parameter CAL_TIMEOUT, default 100000: maximum cycles in WAIT_CAL.
REQ-003 Parameter LOCK_TIMEOUT, default 100000: maximum cycles in WAIT_LOCK.
REQ-004 Parameter STABLE_CYC, default 1000: consecutive synced-lock cycles required.
REQ-005 Parameter MCGB_CYC, default 64: cycles mcgb_rst is held after lock is stable.
REQ-006 Parameter MAX_RETRY, default 8, range 1..15: failed attempts before FAULT.
REQ-007 clk  in  1  single system clock; all logic on its rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 restart  in  1  single-cycle request to rerun the full sequence.
REQ-010 pll_locked  in  1  PLL lock flag, asynchronous to clk.
REQ-011 pll_cal_busy  in  1  PLL calibration busy, asynchronous to clk.
REQ-012 pll_powerdown  out  1  PLL power-down drive.
REQ-013 mcgb_rst  out  1  master clock-generation-block reset drive.
REQ-014 tx_pll_ready  out  1  serial clock is valid; downstream TX reset may release.
REQ-015 fault  out  1  retries exhausted.
REQ-016 retry_cnt  out  4  failed attempts since last rst/restart.
REQ-017 state_o  out  3  current state code.

Function
REQ-018 pll_locked and pll_cal_busy SHALL pass through 2-flop synchronizers; all decisions use synced values (locked_s, busy_s), adding 2 cycles of input latency.
REQ-019 States and codes SHALL be PWRDN=0, WAIT_CAL=1, WAIT_LOCK=2, STABLE=3, MCGB=4, READY=5, FAULT=6; one shared cycle counter, cleared on every state entry.
REQ-020 PWRDN: pll_powerdown=1 for exactly PWRDN_CYC cycles, then WAIT_CAL.
REQ-021 WAIT_CAL: pll_powerdown=0; exit to WAIT_LOCK on first cycle busy_s=0; timeout after CAL_TIMEOUT cycles.
REQ-022 WAIT_LOCK: exit to STABLE on first cycle locked_s=1; timeout after LOCK_TIMEOUT cycles.
REQ-023 STABLE: after STABLE_CYC consecutive locked_s=1 cycles go to MCGB; any locked_s=0 returns to WAIT_LOCK with counter cleared; not counted as a retry.
REQ-024 MCGB: mcgb_rst=1 for exactly MCGB_CYC cycles, then READY.
REQ-025 mcgb_rst SHALL be 1 in every state except READY; tx_pll_ready SHALL be 1 only in READY (registered, asserted the cycle state_o=5).
REQ-026 READY: locked_s=0 for one cycle SHALL drop tx_pll_ready and assert mcgb_rst next cycle, count as a failed attempt.
REQ-027 Failed attempt (timeout or READY lock loss): retry_cnt+1; if new value equals MAX_RETRY go to FAULT, else PWRDN.
REQ-028 FAULT: pll_powerdown=1, mcgb_rst=1, fault=1, tx_pll_ready=0; held until restart or rst; retry_cnt holds.
REQ-029 restart=1 in any state SHALL go to PWRDN next cycle, clear retry_cnt and fault; restart has priority over timeout, lock loss and normal transitions in the same cycle.
REQ-030 Counter width SHALL cover the largest parameter; no wrap before terminal count.

Reset
REQ-031 While rst=1: state=PWRDN, counter=0, pll_powerdown=1, mcgb_rst=1, tx_pll_ready=0, fault=0, retry_cnt=0, synchronizers cleared; rst overrides restart.
REQ-032 First cycle after rst deasserts SHALL be PWRDN count 0; rst mid-sequence, including in READY, restarts identically.

Verification (PWRDN_CYC=4, CAL_TIMEOUT=20, LOCK_TIMEOUT=20, STABLE_CYC=8, MCGB_CYC=3, MAX_RETRY=2)
REQ-033 Nominal: busy low, locked high after rst -> powerdown high 4 cycles, READY reached, mcgb_rst low and tx_pll_ready high same cycle, retry_cnt=0.
REQ-034 Lock glitch: locked low 1 cycle at STABLE count 5 -> back to WAIT_LOCK, retry_cnt stays 0, READY after 8 further stable cycles.
REQ-035 Lock never asserts -> two 20-cycle timeouts, retry_cnt=2, FAULT, fault=1, pll_powerdown=1.
REQ-036 In READY, drop locked 1 cycle -> tx_pll_ready=0 within 3 cycles of input edge, retry_cnt=1, PWRDN re-entered.
REQ-037 restart in same cycle as a WAIT_LOCK timeout -> PWRDN, retry_cnt=0, fault=0; restart in FAULT -> full recovery to READY.

Source files
------------

// File: rtl/kr_pll_rst_seq.sv
// TX PLL bring-up sequencer: power-down, calibration wait, lock qualification,
// MCGB reset release, with bounded retries and a latched fault state.
module kr_pll_rst_seq #(
  parameter int unsigned PWRDN_CYC    = 200,
  parameter int unsigned CAL_TIMEOUT  = 100000,
  parameter int unsigned LOCK_TIMEOUT = 100000,
  parameter int unsigned STABLE_CYC   = 1000,
  parameter int unsigned MCGB_CYC     = 64,
  parameter int unsigned MAX_RETRY    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic       pll_locked,
  input  logic       pll_cal_busy,
  output logic       pll_powerdown,
  output logic       mcgb_rst,
  output logic       tx_pll_ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [2:0] state_o
);

  localparam int unsigned M1   = (PWRDN_CYC > CAL_TIMEOUT) ? PWRDN_CYC : CAL_TIMEOUT;
  localparam int unsigned M2   = (M1 > LOCK_TIMEOUT) ? M1 : LOCK_TIMEOUT;
  localparam int unsigned M3   = (M2 > STABLE_CYC) ? M2 : STABLE_CYC;
  localparam int unsigned MAXP = (M3 > MCGB_CYC) ? M3 : MCGB_CYC;
  localparam int unsigned CW   = $clog2(MAXP + 1);

  localparam logic [CW-1:0] CNT_MAX     = '1;
  localparam logic [CW-1:0] PWRDN_LAST  = CW'(PWRDN_CYC - 1);
  localparam logic [CW-1:0] CAL_LAST    = CW'(CAL_TIMEOUT - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0] MCGB_LAST   = CW'(MCGB_CYC - 1);
  localparam logic [3:0]    RETRY_LIM   = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    PWRDN     = 3'd0,
    WAIT_CAL  = 3'd1,
    WAIT_LOCK = 3'd2,
    STABLE    = 3'd3,
    MCGB      = 3'd4,
    READY     = 3'd5,
    FAULT     = 3'd6
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          cnt_clr;
  logic [3:0]    retry_nx;
  logic [3:0]    retry_inc;
  logic          fail;
  logic          locked_m, locked_s, busy_m, busy_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
      busy_m   <= 1'b0;
      busy_s   <= 1'b0;
    end else begin
      locked_m <= pll_locked;
      locked_s <= locked_m;
      busy_m   <= pll_cal_busy;
      busy_s   <= busy_m;
    end
  end

  assign retry_inc = retry_cnt + 4'd1;

  always_comb begin
    state_nx = state;
    retry_nx = retry_cnt;
    fail     = 1'b0;
    case (state)
      PWRDN:     if (cnt == PWRDN_LAST) state_nx = WAIT_CAL;
      WAIT_CAL: begin
        if (!busy_s)               state_nx = WAIT_LOCK;
        else if (cnt == CAL_LAST)  fail = 1'b1;
      end
      WAIT_LOCK: begin
        if (locked_s)              state_nx = STABLE;
        else if (cnt == LOCK_LAST) fail = 1'b1;
      end
      // only cycles spent in STABLE count toward qualification
      STABLE: begin
        if (!locked_s)               state_nx = WAIT_LOCK;
        else if (cnt == STABLE_LAST) state_nx = MCGB;
      end
      MCGB:      if (cnt == MCGB_LAST) state_nx = READY;
      READY:     if (!locked_s) fail = 1'b1;
      FAULT:     state_nx = FAULT;
      default:   state_nx = PWRDN;
    endcase
    if (fail) begin
      retry_nx = retry_inc;
      state_nx = (retry_inc == RETRY_LIM) ? FAULT : PWRDN;
    end
    if (restart) begin
      state_nx = PWRDN;
      retry_nx = '0;
    end
    cnt_clr = restart || (state_nx != state);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PWRDN;
      cnt       <= '0;
      retry_cnt <= '0;
    end else begin
      state     <= state_nx;
      retry_cnt <= retry_nx;
      if (cnt_clr)             cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end
  end

  assign pll_powerdown = (state == PWRDN) || (state == FAULT);
  assign mcgb_rst      = (state != READY);
  assign tx_pll_ready  = (state == READY);
  assign fault         = (state == FAULT);
  assign state_o       = state;

endmodule

// File: tb/tb_kr_pll_rst_seq.sv
// Directed table-driven bench for kr_pll_rst_seq with reduced timing parameters.
module tb_kr_pll_rst_seq;

  logic       clk = 1'b0;
  logic       rst, restart, pll_locked, pll_cal_busy;
  logic       pll_powerdown, mcgb_rst, tx_pll_ready, fault;
  logic [3:0] retry_cnt;
  logic [2:0] state_o;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  localparam logic [2:0] S_PD = 3'd0, S_CAL = 3'd1, S_LK = 3'd2, S_ST = 3'd3,
                         S_MC = 3'd4, S_RDY = 3'd5, S_FLT = 3'd6;

  always #5 clk = ~clk;

  kr_pll_rst_seq #(
    .PWRDN_CYC(4), .CAL_TIMEOUT(20), .LOCK_TIMEOUT(20),
    .STABLE_CYC(8), .MCGB_CYC(3), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst(rst), .restart(restart), .pll_locked(pll_locked),
    .pll_cal_busy(pll_cal_busy), .pll_powerdown(pll_powerdown), .mcgb_rst(mcgb_rst),
    .tx_pll_ready(tx_pll_ready), .fault(fault), .retry_cnt(retry_cnt), .state_o(state_o)
  );

  typedef struct {
    logic        rst, restart, locked, busy;
    int unsigned n;
    logic [2:0]  st;
    logic [3:0]  retry;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic rs, input logic lk, input logic bz,
                     input int unsigned n, input logic [2:0] st, input logic [3:0] rc);
    vec_t v;
    v.rst = r; v.restart = rs; v.locked = lk; v.busy = bz;
    v.n = n; v.st = st; v.retry = rc;
    tbl.push_back(v);
  endtask

  // expected output word {state, pd, mcgb, rdy, fault, retry} implied by a state
  function automatic logic [10:0] exp_word(input logic [2:0] st, input logic [3:0] rc);
    logic pd, mc, rd, fl;
    pd = (st == S_PD) || (st == S_FLT);
    mc = (st != S_RDY);
    rd = (st == S_RDY);
    fl = (st == S_FLT);
    return {st, pd, mc, rd, fl, rc};
  endfunction

  task automatic check(input string name, input logic [10:0] exp);
    logic [10:0] act;
    act = {state_o, pll_powerdown, mcgb_rst, tx_pll_ready, fault, retry_cnt};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got st=%0d pd=%b mcgb=%b rdy=%b flt=%b retry=%0d ; want st=%0d pd=%b mcgb=%b rdy=%b flt=%b retry=%0d",
               name, act[10:8], act[7], act[6], act[5], act[4], act[3:0],
               exp[10:8], exp[7], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  task automatic add_bringup(input logic [3:0] rc);
    add(0, 0, 1, 0, 3, S_PD,  rc);
    add(0, 0, 1, 0, 1, S_CAL, rc);
    add(0, 0, 1, 0, 1, S_LK,  rc);
    add(0, 0, 1, 0, 8, S_ST,  rc);
    add(0, 0, 1, 0, 3, S_MC,  rc);
    add(0, 0, 1, 0, 2, S_RDY, rc);
  endtask

  initial begin
    int unsigned edges;
    logic        seen;

    rst = 1'b1; restart = 1'b0; pll_locked = 1'b1; pll_cal_busy = 1'b0;

    // nominal bring-up from reset
    add(1, 0, 1, 0, 3, S_PD, 0);
    add_bringup(0);
    // lock loss in READY counts as a retry
    add(0, 0, 0, 0, 1, S_RDY, 0);
    add(0, 0, 1, 0, 1, S_RDY, 0);
    add(0, 0, 1, 0, 1, S_PD,  1);
    add_bringup(1);
    // restart clears retry, then a lock glitch at STABLE count 5
    add(0, 1, 1, 0, 1, S_PD,  0);
    add(0, 0, 1, 0, 3, S_PD,  0);
    add(0, 0, 1, 0, 1, S_CAL, 0);
    add(0, 0, 1, 0, 1, S_LK,  0);
    add(0, 0, 1, 0, 4, S_ST,  0);
    add(0, 0, 0, 0, 1, S_ST,  0);
    add(0, 0, 1, 0, 1, S_ST,  0);
    add(0, 0, 1, 0, 1, S_LK,  0);
    add(0, 0, 1, 0, 8, S_ST,  0);
    add(0, 0, 1, 0, 3, S_MC,  0);
    add(0, 0, 1, 0, 2, S_RDY, 0);
    // lock never asserts: two timeouts then FAULT
    add(0, 1, 0, 0, 1,  S_PD,  0);
    add(0, 0, 0, 0, 3,  S_PD,  0);
    add(0, 0, 0, 0, 1,  S_CAL, 0);
    add(0, 0, 0, 0, 20, S_LK,  0);
    add(0, 0, 0, 0, 4,  S_PD,  1);
    add(0, 0, 0, 0, 1,  S_CAL, 1);
    add(0, 0, 0, 0, 20, S_LK,  1);
    add(0, 0, 0, 0, 5,  S_FLT, 2);
    // restart out of FAULT, calibration held busy for a while
    add(0, 1, 1, 1, 1, S_PD,  0);
    add(0, 0, 1, 1, 3, S_PD,  0);
    add(0, 0, 1, 1, 3, S_CAL, 0);
    add(0, 0, 1, 0, 2, S_CAL, 0);
    add(0, 0, 1, 0, 1, S_LK,  0);
    add(0, 0, 1, 0, 8, S_ST,  0);
    add(0, 0, 1, 0, 3, S_MC,  0);
    add(0, 0, 1, 0, 2, S_RDY, 0);
    // restart coincides with the final WAIT_LOCK timeout cycle (would be FAULT)
    add(0, 0, 0, 0, 2,  S_RDY, 0);
    add(0, 0, 0, 0, 1,  S_PD,  1);
    add(0, 0, 0, 0, 3,  S_PD,  1);
    add(0, 0, 0, 0, 1,  S_CAL, 1);
    add(0, 0, 0, 0, 20, S_LK,  1);
    add(0, 1, 0, 0, 1,  S_PD,  0);
    add_bringup(0);

    for (int i = 0; i < tbl.size(); i++) begin
      for (int unsigned c = 0; c < tbl[i].n; c++) begin
        rst          = tbl[i].rst;
        restart      = tbl[i].restart;
        pll_locked   = tbl[i].locked;
        pll_cal_busy = tbl[i].busy;
        @(posedge clk); #1;
        check($sformatf("row%0d_cyc%0d", i, c), exp_word(tbl[i].st, tbl[i].retry));
      end
    end

    // READY lock loss to get retry=1, then rst mid-sequence with restart also high
    pll_locked = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("pre_rst_retry", exp_word(S_PD, 1));
    pll_locked = 1'b1;
    rst = 1'b1; restart = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_over_restart", exp_word(S_PD, 0));
    end
    rst = 1'b0; restart = 1'b0;

    // bounded wait for READY; from reset release it takes 17 edges
    edges = 0;
    seen  = 1'b0;
    for (int unsigned k = 0; k < 60 && !seen; k++) begin
      @(posedge clk); #1;
      edges++;
      if (tx_pll_ready) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || edges != 17) begin
      n_bad++;
      $display("FAIL ready_latency: got %0d edges (seen=%b), want 17", edges, seen);
    end
    check("ready_after_rst", exp_word(S_RDY, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
